tt_sweep_ctrl: RTL and testbench
================================

// Module: tt_sweep_ctrl
// PURPOSE
//   Sequencer that drives the 7 inputs of an attached combinational (or pipelined)
//   majority-gate function through all 2^NIN patterns, one per clock, and captures
//   its output into a truth table plus onset count. It is the front end of the
//   classification flow: one start -> one complete truth table for the function under test.
// PARAMETERS
//   NIN  7  number of function inputs; table width 2^NIN
//   LAT  0  cycles from x_o change to valid f_i (0 = purely combinational function)
// PORTS
//   clk    in   1        clock
//   rst    in   1        asynchronous, active-high reset
//   start  in   1        begin sweep (honoured only in IDLE)
//   abort  in   1        cancel sweep in progress
//   x_o    out  NIN      pattern driven to function inputs (x_o[0] = x0)
//   f_i    in   1        function output for pattern presented LAT cycles earlier
//   busy   out  1        sweep in progress
//   done   out  1        one-cycle pulse: tt/ones valid
//   tt     out  2^NIN    truth table, tt[k] = f(x = k)
//   ones   out  NIN+1    popcount of tt
// BEHAVIOUR
//   Reset: one clock clk; rst asynchronous, active-high. All outputs and state 0,
//     state IDLE.
//   States: IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
//   - IDLE: x_o=0, busy=0. start=1 at edge -> SWEEP; tt, ones cleared same edge.
//   - SWEEP: x_o = 0,1,...,2^NIN-1 on consecutive cycles. After 2^NIN-1 is presented
//     -> DRAIN when LAT>0, else -> DONE.
//   - DRAIN: x_o returns to 0. Lasts LAT cycles while the last samples arrive.
//   - DONE: done=1 for exactly one cycle, busy=0. Next state IDLE.
//   Timing: start seen at cycle 0; x_o=k during cycle 1+k; f_i for pattern k sampled
//     at edge ending cycle 1+k+LAT. busy high cycles 1..2^NIN+LAT. done high at
//     cycle 2^NIN+LAT+1, with tt/ones final.
//   Capture: sample-index counter = pattern counter delayed by LAT (valid shift
//     pipe). tt[idx] <= f_i. ones += f_i on each valid sample. Width NIN+1 holds
//     2^NIN without overflow.
//   tt/ones hold after done until next accepted start.
//   start while busy or in DONE: ignored. start and abort in IDLE together: abort
//     wins, no sweep.
//   abort in SWEEP/DRAIN: next edge -> IDLE; x_o=0; tt, ones cleared; no done pulse;
//     in-flight samples discarded. abort in DONE: ignored (done still pulses).
//   Pattern counter wraps only by leaving SWEEP; no x_o value is repeated or skipped.
//   rst mid-sweep: immediate return to reset state; no done.
// CONFIGURATION
//   TT_SELFDUAL_EN defined: extra output selfdual (1 bit). Computed in DONE cycle:
//     1 iff tt[k] != tt[2^NIN-1-k] for all k (f(~x) = ~f(x)). Registered: valid with
//     done, held until next start. Cleared by reset/start/abort.
//   TT_SELFDUAL_EN undefined: port and logic absent; all other behaviour identical.
// TESTING
//   f=0, LAT=0, start -> done at cycle 129; tt=0, ones=0; x_o traced 0..127 exactly once.
//   f=MAJ(x0,x1,x2) -> ones=64, tt[7]=1, tt[3]=1, tt[4]=0; with TT_SELFDUAL_EN, selfdual=1.
//   f=x0&x1, LAT=2 (2-stage register) -> done at cycle 131; tt[3]=1, ones=32;
//     with TT_SELFDUAL_EN, selfdual=0.
//   abort at cycle 50 -> busy low cycle 51, no done, tt=0, ones=0; start at 55 sweeps
//     normally.
//   start pulses at cycles 10 and 129 of a sweep -> ignored; exactly one done.
//   rst asserted cycle 60 asynchronously -> all outputs 0 before next edge; restart
//     gives full correct table.

Source files
------------

// File: rtl/tt_sweep_ctrl_if.sv
// Pattern / sample / result bundle between the truth-table sweep sequencer and its user.
// The selfdual result is present only when TT_SELFDUAL_EN is defined.
interface tt_sweep_ctrl_if #(
    parameter int NIN = 7
) ();
    logic                  start;
    logic                  abort;
    logic [NIN-1:0]        x_o;
    logic                  f_i;
    logic                  busy;
    logic                  done;
    logic [(1<<NIN)-1:0]   tt;
    logic [NIN:0]          ones;
`ifdef TT_SELFDUAL_EN
    logic                  selfdual;

    modport master (output start, abort, f_i, input x_o, busy, done, tt, ones, selfdual);
    modport slave  (input start, abort, f_i, output x_o, busy, done, tt, ones, selfdual);
`else
    modport master (output start, abort, f_i, input x_o, busy, done, tt, ones);
    modport slave  (input start, abort, f_i, output x_o, busy, done, tt, ones);
`endif
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 2^NIN input patterns of an attached function (LAT cycles deep) and captures its
// truth table and onset count. Optional TT_SELFDUAL_EN adds a registered self-duality flag.
module tt_sweep_ctrl #(
    parameter int NIN = 7,
    parameter int LAT = 0
) (
    input logic            clk,
    input logic            rst,
    tt_sweep_ctrl_if.slave bus
);
    localparam int TT_W = 1 << NIN;
    localparam int DW   = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t              state_r;
    state_t              state_nxt;
    logic [NIN-1:0]      x_o_r;
    logic [NIN-1:0]      x_o_nxt;
    logic                busy_r;
    logic                done_r;
    logic [TT_W-1:0]     tt_r;
    logic [TT_W-1:0]     tt_nxt;
    logic [NIN:0]        ones_r;
    logic [NIN:0]        ones_nxt;
    logic [DW-1:0]       drain_r;
    logic                start_ok_s;
    logic                abort_sweep_s;
    logic                cap_en_s;
    logic                samp_vld_s;
    logic [NIN-1:0]      samp_idx_s;

    // f(~x) == ~f(x) for every x: each table entry differs from its mirrored entry
    function automatic logic sd_check(input logic [TT_W-1:0] t);
        logic r;
        r = 1'b1;
        for (int k = 0; k < TT_W; k++) begin
            if (t[k] == t[TT_W-1-k]) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

    assign start_ok_s    = (state_r == IDLE) && bus.start && !bus.abort;
    assign abort_sweep_s = bus.abort && ((state_r == SWEEP) || (state_r == DRAIN));
    assign cap_en_s      = samp_vld_s && ((state_r == SWEEP) || (state_r == DRAIN)) && !bus.abort;

    generate
        if (LAT == 0) begin : g_nopipe
            // Purely combinational function: the sample belongs to the pattern on x_o now
            always_comb begin
                samp_vld_s = (state_r == SWEEP);
                samp_idx_s = x_o_r;
            end
        end else begin : g_pipe
            logic [LAT-1:0] vld_r;
            logic [NIN-1:0] idx_r [LAT];

            // Valid/index shift pipe aligning captured samples with the function latency
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_r <= '0;
                    for (int i = 0; i < LAT; i++) idx_r[i] <= '0;
                end else if (abort_sweep_s) begin
                    vld_r <= '0;
                    for (int i = 0; i < LAT; i++) idx_r[i] <= '0;
                end else begin
                    vld_r[0] <= (state_r == SWEEP);
                    idx_r[0] <= x_o_r;
                    for (int i = 1; i < LAT; i++) begin
                        vld_r[i] <= vld_r[i-1];
                        idx_r[i] <= idx_r[i-1];
                    end
                end
            end

            assign samp_vld_s = vld_r[LAT-1];
            assign samp_idx_s = idx_r[LAT-1];
        end
    endgenerate

    // Next-state and next pattern decode
    always_comb begin
        state_nxt = state_r;
        x_o_nxt   = '0;
        case (state_r)
            IDLE: begin
                if (start_ok_s) state_nxt = SWEEP;
                else            state_nxt = IDLE;
            end
            SWEEP: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (x_o_r == '1) begin
                    if (LAT > 0) state_nxt = DRAIN;
                    else         state_nxt = DONE;
                end else begin
                    state_nxt = SWEEP;
                    x_o_nxt   = x_o_r + NIN'(1'b1);
                end
            end
            DRAIN: begin
                if (bus.abort)                      state_nxt = IDLE;
                else if (drain_r == DW'(LAT - 1))   state_nxt = DONE;
                else                                state_nxt = DRAIN;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Truth-table and onset-count update
    always_comb begin
        tt_nxt   = tt_r;
        ones_nxt = ones_r;
        if (start_ok_s || abort_sweep_s) begin
            tt_nxt   = '0;
            ones_nxt = '0;
        end else if (cap_en_s) begin
            tt_nxt[samp_idx_s] = bus.f_i;
            ones_nxt           = ones_r + (NIN+1)'(bus.f_i);
        end else begin
            tt_nxt   = tt_r;
            ones_nxt = ones_r;
        end
    end

    // State, pattern, status and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            x_o_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            tt_r    <= '0;
            ones_r  <= '0;
            drain_r <= '0;
        end else begin
            state_r <= state_nxt;
            x_o_r   <= x_o_nxt;
            busy_r  <= (state_nxt == SWEEP) || (state_nxt == DRAIN);
            done_r  <= (state_nxt == DONE);
            tt_r    <= tt_nxt;
            ones_r  <= ones_nxt;
            if (state_r == DRAIN) drain_r <= drain_r + DW'(1);
            else                  drain_r <= '0;
        end
    end

    assign bus.x_o  = x_o_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.tt   = tt_r;
    assign bus.ones = ones_r;

`ifdef TT_SELFDUAL_EN
    logic selfdual_r;

    // Self-duality flag, judged on the final table so it is valid alongside done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            selfdual_r <= 1'b0;
        end else if (start_ok_s || abort_sweep_s) begin
            selfdual_r <= 1'b0;
        end else if (state_nxt == DONE) begin
            selfdual_r <= sd_check(tt_nxt);
        end else begin
            selfdual_r <= selfdual_r;
        end
    end

    assign bus.selfdual = selfdual_r;
`endif
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: one combinational instance (LAT=0) and one behind a
// 2-stage register (LAT=2); selfdual is checked when TT_SELFDUAL_EN is defined.
module tb_tt_sweep_ctrl;
    localparam int NIN = 7;
    localparam int TW  = 1 << NIN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    fsel = 2'd0;
    logic          p1 = 1'b0;
    logic          p2 = 1'b0;
    logic [TW-1:0] exp_tt;
    int            n_chk = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    tt_sweep_ctrl_if #(.NIN(NIN)) bus0 ();
    tt_sweep_ctrl_if #(.NIN(NIN)) bus2 ();

    tt_sweep_ctrl #(.NIN(NIN), .LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    tt_sweep_ctrl #(.NIN(NIN), .LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    function automatic logic fn(input logic [NIN-1:0] x, input logic [1:0] s);
        case (s)
            2'd1:    fn = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
            2'd2:    fn = x[0] & x[1];
            default: fn = 1'b0;
        endcase
    endfunction

    assign bus0.f_i = fn(bus0.x_o, fsel);
    always @(posedge clk) begin
        p1 <= fn(bus2.x_o, fsel);
        p2 <= p1;
    end
    assign bus2.f_i = p2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp(input logic [1:0] s);
        for (int k = 0; k < TW; k++) exp_tt[k] = fn(7'(k), s);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus0.start = 1'b0; bus0.abort = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0;
        repeat (3) tick();
        n_chk++;
        if ({bus0.busy, bus0.done, bus0.x_o, bus0.tt, bus0.ones} !== '0)
            $display("FAIL reset_dut0: got busy=%b done=%b x=%h ones=%0d want all 0", bus0.busy, bus0.done, bus0.x_o, bus0.ones);
        else n_pass++;
        n_chk++;
        if ({bus2.busy, bus2.done, bus2.x_o, bus2.tt, bus2.ones} !== '0)
            $display("FAIL reset_dut2: got busy=%b done=%b x=%h ones=%0d want all 0", bus2.busy, bus2.done, bus2.x_o, bus2.ones);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_sweep;
        fsel = 2'd0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int c = 1; c <= 128; c++) begin
            n_chk++;
            if ({bus0.busy, bus0.done, bus0.x_o} !== {1'b1, 1'b0, 7'(c - 1)})
                $display("FAIL zero_trace c=%0d: got busy=%b done=%b x=%0d want 1 0 %0d", c, bus0.busy, bus0.done, bus0.x_o, c - 1);
            else n_pass++;
            tick();
        end
        n_chk++;
        if ({bus0.done, bus0.busy, bus0.x_o} !== {1'b1, 1'b0, 7'd0})
            $display("FAIL zero_done129: got done=%b busy=%b x=%0d want 1 0 0", bus0.done, bus0.busy, bus0.x_o);
        else n_pass++;
        n_chk++;
        if ({bus0.tt, bus0.ones} !== '0)
            $display("FAIL zero_table: got ones=%0d tt=%h want 0", bus0.ones, bus0.tt);
        else n_pass++;
        tick();
        n_chk++;
        if (bus0.done !== 1'b0) $display("FAIL zero_done_width: got done=%b want 0", bus0.done);
        else n_pass++;
    endtask

    task automatic test_maj;
        fsel = 2'd1;
        build_exp(2'd1);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (128) tick();
        n_chk++;
        if (bus0.done !== 1'b1) $display("FAIL maj_done: got %b want 1", bus0.done);
        else n_pass++;
        n_chk++;
        if (bus0.tt !== exp_tt) $display("FAIL maj_tt: got %h want %h", bus0.tt, exp_tt);
        else n_pass++;
        n_chk++;
        if (bus0.ones !== 8'd64) $display("FAIL maj_ones: got %0d want 64", bus0.ones);
        else n_pass++;
        n_chk++;
        if ({bus0.tt[7], bus0.tt[3], bus0.tt[4]} !== 3'b110)
            $display("FAIL maj_bits: got tt7=%b tt3=%b tt4=%b want 1 1 0", bus0.tt[7], bus0.tt[3], bus0.tt[4]);
        else n_pass++;
`ifdef TT_SELFDUAL_EN
        n_chk++;
        if (bus0.selfdual !== 1'b1) $display("FAIL maj_selfdual: got %b want 1", bus0.selfdual);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_lat2;
        fsel = 2'd2;
        build_exp(2'd2);
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int c = 1; c <= 130; c++) begin
            n_chk++;
            if ({bus2.busy, bus2.done, bus2.x_o} !== {1'b1, 1'b0, (c <= 128) ? 7'(c - 1) : 7'd0})
                $display("FAIL lat2_trace c=%0d: got busy=%b done=%b x=%0d", c, bus2.busy, bus2.done, bus2.x_o);
            else n_pass++;
            tick();
        end
        n_chk++;
        if ({bus2.done, bus2.busy} !== 2'b10) $display("FAIL lat2_done131: got done=%b busy=%b want 1 0", bus2.done, bus2.busy);
        else n_pass++;
        n_chk++;
        if (bus2.tt !== exp_tt) $display("FAIL lat2_tt: got %h want %h", bus2.tt, exp_tt);
        else n_pass++;
        n_chk++;
        if ({bus2.tt[3], bus2.ones} !== {1'b1, 8'd32}) $display("FAIL lat2_ones: got tt3=%b ones=%0d want 1 32", bus2.tt[3], bus2.ones);
        else n_pass++;
`ifdef TT_SELFDUAL_EN
        n_chk++;
        if (bus2.selfdual !== 1'b0) $display("FAIL lat2_selfdual: got %b want 0", bus2.selfdual);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_abort;
        fsel = 2'd1;
        build_exp(2'd1);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (49) tick();
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        n_chk++;
        if ({bus0.busy, bus0.done, bus0.x_o, bus0.tt, bus0.ones} !== '0)
            $display("FAIL abort_clear: got busy=%b done=%b x=%0d ones=%0d want all 0", bus0.busy, bus0.done, bus0.x_o, bus0.ones);
        else n_pass++;
        for (int c = 51; c < 55; c++) begin
            n_chk++;
            if ({bus0.busy, bus0.done} !== 2'b00) $display("FAIL abort_idle c=%0d: got busy=%b done=%b want 0 0", c, bus0.busy, bus0.done);
            else n_pass++;
            tick();
        end
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (128) tick();
        n_chk++;
        if ({bus0.done, bus0.ones} !== {1'b1, 8'd64}) $display("FAIL abort_restart: got done=%b ones=%0d want 1 64", bus0.done, bus0.ones);
        else n_pass++;
        n_chk++;
        if (bus0.tt !== exp_tt) $display("FAIL abort_restart_tt: got %h want %h", bus0.tt, exp_tt);
        else n_pass++;
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        n_chk++;
        if ({bus0.busy, bus0.tt, bus0.ones} !== {1'b0, exp_tt, 8'd64}) $display("FAIL abort_in_done: got busy=%b ones=%0d want 0 64", bus0.busy, bus0.ones);
        else n_pass++;
        bus0.start = 1'b1;
        bus0.abort = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        tick();
        n_chk++;
        if ({bus0.busy, bus0.tt, bus0.ones} !== {1'b0, exp_tt, 8'd64}) $display("FAIL abort_wins: got busy=%b ones=%0d want 0 64", bus0.busy, bus0.ones);
        else n_pass++;
    endtask

    task automatic test_start_ignored;
        int ndone;
        ndone = 0;
        fsel = 2'd2;
        build_exp(2'd2);
        bus0.start = 1'b1;
        tick();
        for (int c = 1; c <= 140; c++) begin
            ndone += int'(bus0.done);
            bus0.start = (c == 10) || (c == 129);
            tick();
        end
        bus0.start = 1'b0;
        n_chk++;
        if (ndone != 1) $display("FAIL start_ignored_done: got %0d pulses want 1", ndone);
        else n_pass++;
        n_chk++;
        if ({bus0.busy, bus0.tt, bus0.ones} !== {1'b0, exp_tt, 8'd32}) $display("FAIL start_ignored_table: got busy=%b ones=%0d want 0 32", bus0.busy, bus0.ones);
        else n_pass++;
    endtask

    task automatic test_rst_mid;
        fsel = 2'd1;
        build_exp(2'd1);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (59) tick();
        #2 rst = 1'b1;
        #1;
        n_chk++;
`ifdef TT_SELFDUAL_EN
        if ({bus0.busy, bus0.done, bus0.x_o, bus0.tt, bus0.ones, bus0.selfdual} !== '0)
`else
        if ({bus0.busy, bus0.done, bus0.x_o, bus0.tt, bus0.ones} !== '0)
`endif
            $display("FAIL rst_async: got busy=%b x=%0d ones=%0d want all 0", bus0.busy, bus0.x_o, bus0.ones);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (128) tick();
        n_chk++;
        if ({bus0.done, bus0.tt, bus0.ones} !== {1'b1, exp_tt, 8'd64})
            $display("FAIL rst_restart: got done=%b ones=%0d tt=%h want 1 64 %h", bus0.done, bus0.ones, bus0.tt, exp_tt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_sweep();
        test_maj();
        test_lat2();
        test_abort();
        test_start_ignored();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
